// File: rtl/fifo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_serial_tx
// Purpose  : Drains an upstream FIFO one word at a time and sends each word
//            as an asynchronous serial frame: start bit, WIDTH data bits LSB
//            first, optional even parity bit, stop bit.
// Options  : define FIFO_SERIAL_TX_PARITY_EN to insert the even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             empty_n,
    input  logic [WIDTH-1:0] data_out,
    output logic             read,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY = 3'd6,
`endif
        STOP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               read_q, read_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Last cycle of the current serial bit.
    logic baud_wrap;
    assign baud_wrap = (baud_q == c_baud_last);

    // Next-state logic; outputs are derived from the next state so that every
    // output pin comes straight from a flop with no input-to-output path.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (empty_n) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid in the cycle after the pop pulse.
                shift_d  = data_out;
                baud_d   = '0;
                bit_d    = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                parity_d = ^data_out;
`endif
                state_d  = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == c_bit_last) begin
                        bit_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        read_d       = (state_d == POP);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == STOP) && (baud_d == c_baud_last);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            read_q       <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            read_q       <= read_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // Parity of the captured word, held for the parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign read       = read_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
